// File: rtl/raster_sequencer_pkg.sv
// Shared definitions for the raster sequencer: state encoding, field widths,
// vertex-field offsets within the packed triangle buses, and the pixel payload.
package raster_sequencer_pkg;

  localparam int unsigned COORD_W     = 16;
  localparam int unsigned DEPTH_W     = 2;
  localparam int unsigned ARGB_W      = 16;
  localparam int unsigned NUM_VERTS   = 3;
  localparam int unsigned TRI_XY_W    = 2 * COORD_W * NUM_VERTS;
  localparam int unsigned TRI_DEPTH_W = DEPTH_W * NUM_VERTS;
  localparam int unsigned TRI_COLOR_W = ARGB_W * NUM_VERTS;
  localparam int unsigned TRI_COUNT_W = 16;

  // Bit offsets of vertex v's fields inside in_tri_xy / in_tri_depth / in_tri_color
  function automatic int unsigned vx_off(input int unsigned v);
    return 2 * COORD_W * v;
  endfunction

  function automatic int unsigned vy_off(input int unsigned v);
    return 2 * COORD_W * v + COORD_W;
  endfunction

  function automatic int unsigned depth_off(input int unsigned v);
    return DEPTH_W * v;
  endfunction

  function automatic int unsigned color_off(input int unsigned v);
    return ARGB_W * v;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BOUND, S_EDGES, S_SETUP, S_RASTER, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [ARGB_W-1:0]  color;
    logic [DEPTH_W-1:0] depth;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pixel_t;

endpackage

// File: rtl/raster_sequencer_if.sv
// Triangle input, rasterizer control/status, pixel stream and status bundle.
interface raster_sequencer_if;
  import raster_sequencer_pkg::*;

  logic                   in_tri_valid;
  logic                   out_tri_ready;
  logic [TRI_XY_W-1:0]    in_tri_xy;
  logic [TRI_DEPTH_W-1:0] in_tri_depth;
  logic [TRI_COLOR_W-1:0] in_tri_color;
  logic [TRI_XY_W-1:0]    out_v_xy;
  logic [TRI_DEPTH_W-1:0] out_v_depth;
  logic [TRI_COLOR_W-1:0] out_v_color;

  logic out_sig_start_new_triangle;
  logic out_sig_get_boundary_coords;
  logic out_sig_form_edges;
  logic out_sig_pixel_loop_setup;
  logic out_sig_rasterize_pixels;
  logic in_sig_rasterize_write_pixel;
  logic in_sig_rasterize_done;

  logic [COORD_W-1:0] in_pixel_x;
  logic [COORD_W-1:0] in_pixel_y;
  logic [DEPTH_W-1:0] in_pixel_depth;
  logic [ARGB_W-1:0]  in_pixel_color;

  logic               out_pix_valid;
  logic               in_pix_ready;
  logic [COORD_W-1:0] out_pix_x;
  logic [COORD_W-1:0] out_pix_y;
  logic [DEPTH_W-1:0] out_pix_depth;
  logic [ARGB_W-1:0]  out_pix_color;

  logic                   out_busy;
  logic                   out_tri_done;
  logic [TRI_COUNT_W-1:0] out_tri_count;
  logic                   out_error;

  modport master (
    input  in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    input  in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    input  in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color, in_pix_ready,
    output out_tri_ready, out_v_xy, out_v_depth, out_v_color,
    output out_sig_start_new_triangle, out_sig_get_boundary_coords, out_sig_form_edges,
    output out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    output out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    output out_busy, out_tri_done, out_tri_count, out_error
  );

  modport slave (
    output in_tri_valid, in_tri_xy, in_tri_depth, in_tri_color,
    output in_sig_rasterize_write_pixel, in_sig_rasterize_done,
    output in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color, in_pix_ready,
    input  out_tri_ready, out_v_xy, out_v_depth, out_v_color,
    input  out_sig_start_new_triangle, out_sig_get_boundary_coords, out_sig_form_edges,
    input  out_sig_pixel_loop_setup, out_sig_rasterize_pixels,
    input  out_pix_valid, out_pix_x, out_pix_y, out_pix_depth, out_pix_color,
    input  out_busy, out_tri_done, out_tri_count, out_error
  );

endinterface

// File: rtl/raster_sequencer_pixel_skid_buf.sv
// One-entry valid/ready pixel register between the rasterizer and downstream.
module pixel_skid_buf
  import raster_sequencer_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   i_load,
  input  pixel_t i_pix,
  input  logic   i_ready,
  output logic   o_valid,
  output pixel_t o_pix
);

  logic   r_valid;
  pixel_t r_pix;

  // Load only happens when empty or draining, so held data is never overwritten
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pix   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pix   <= i_pix;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pix   = r_pix;

endmodule

// File: rtl/raster_sequencer.sv
// Sequences one triangle through the rasterizer setup phases, streams its
// pixels through a one-entry buffer, and guards the raster phase with a timeout.
module raster_sequencer
  import raster_sequencer_pkg::*;
#(
  parameter int unsigned PHASE_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic clock,
  input logic reset,
  raster_sequencer_if.master bus
);

  localparam int unsigned PC_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t                 r_state, w_next;
  logic [PC_W-1:0]        r_phase_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [3:0]             r_phase;
  logic                   r_tri_ready, r_busy, r_tri_done, r_error;
  logic [TRI_COUNT_W-1:0] r_tri_count;
  logic [TRI_XY_W-1:0]    r_v_xy;
  logic [TRI_DEPTH_W-1:0] r_v_depth;
  logic [TRI_COLOR_W-1:0] r_v_color;

  logic   w_pix_valid, w_rast, w_load, w_wp, w_done, w_phase_end, w_timeout, w_in_phase;
  pixel_t w_pix_in, w_pix_out;

  assign w_wp        = bus.in_sig_rasterize_write_pixel;
  assign w_done      = bus.in_sig_rasterize_done;
  assign w_rast      = (r_state == S_RASTER) && (!w_pix_valid || bus.in_pix_ready);
  assign w_load      = w_rast && w_wp;
  assign w_in_phase  = (r_state inside {S_START, S_BOUND, S_EDGES, S_SETUP});
  assign w_phase_end = (r_phase_cnt == PC_W'(PHASE_CYCLES - 1));
  assign w_timeout   = w_rast && !w_wp && !w_done && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_pix_in    = {bus.in_pixel_color, bus.in_pixel_depth, bus.in_pixel_y, bus.in_pixel_x};

  pixel_skid_buf u_pix_buf (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_load),
    .i_pix   (w_pix_in),
    .i_ready (bus.in_pix_ready),
    .o_valid (w_pix_valid),
    .o_pix   (w_pix_out)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.in_tri_valid && r_tri_ready) w_next = S_START;
      S_START:  if (w_phase_end) w_next = S_BOUND;
      S_BOUND:  if (w_phase_end) w_next = S_EDGES;
      S_EDGES:  if (w_phase_end) w_next = S_SETUP;
      S_SETUP:  if (w_phase_end) w_next = S_RASTER;
      S_RASTER: if ((w_rast && w_done) || w_timeout) w_next = S_DRAIN;
      S_DRAIN:  if (!w_pix_valid || bus.in_pix_ready) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Status/phase outputs are registered from the next state so they align with it
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_to_cnt    <= '0;
      r_phase     <= '0;
      r_tri_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_tri_done  <= 1'b0;
      r_error     <= 1'b0;
      r_tri_count <= '0;
      r_v_xy      <= '0;
      r_v_depth   <= '0;
      r_v_color   <= '0;
    end else begin
      r_state     <= w_next;
      r_tri_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_tri_done  <= (w_next == S_DONE);
      r_phase     <= {w_next == S_SETUP, w_next == S_EDGES, w_next == S_BOUND, w_next == S_START};

      if (w_in_phase && (w_next == r_state)) r_phase_cnt <= r_phase_cnt + PC_W'(1);
      else                                   r_phase_cnt <= '0;

      if (r_state == S_IDLE && w_next == S_START) begin
        r_v_xy    <= bus.in_tri_xy;
        r_v_depth <= bus.in_tri_depth;
        r_v_color <= bus.in_tri_color;
      end

      // Watchdog: only advancing raster cycles without progress count toward timeout
      if (w_next == S_RASTER && r_state != S_RASTER)   r_to_cnt <= '0;
      else if (r_state == S_RASTER && (w_wp || w_done)) r_to_cnt <= '0;
      else if (w_rast)                                  r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_timeout) r_error <= 1'b1;
      if (w_next == S_DONE) r_tri_count <= r_tri_count + TRI_COUNT_W'(1);
    end
  end

  assign bus.out_tri_ready               = r_tri_ready;
  assign bus.out_v_xy                    = r_v_xy;
  assign bus.out_v_depth                 = r_v_depth;
  assign bus.out_v_color                 = r_v_color;
  assign bus.out_sig_start_new_triangle  = r_phase[0];
  assign bus.out_sig_get_boundary_coords = r_phase[1];
  assign bus.out_sig_form_edges          = r_phase[2];
  assign bus.out_sig_pixel_loop_setup    = r_phase[3];
  assign bus.out_sig_rasterize_pixels    = w_rast;
  assign bus.out_pix_valid               = w_pix_valid;
  assign bus.out_pix_x                   = w_pix_out.x;
  assign bus.out_pix_y                   = w_pix_out.y;
  assign bus.out_pix_depth               = w_pix_out.depth;
  assign bus.out_pix_color               = w_pix_out.color;
  assign bus.out_busy                    = r_busy;
  assign bus.out_tri_done                = r_tri_done;
  assign bus.out_tri_count               = r_tri_count;
  assign bus.out_error                   = r_error;

endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench for raster_sequencer with TIMEOUT=16 and single-cycle phases.
module tb_raster_sequencer;
  import raster_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  pixel_t rx_q[$];

  logic [TRI_XY_W-1:0]    tri_xy;
  logic [TRI_DEPTH_W-1:0] tri_depth;
  logic [TRI_COLOR_W-1:0] tri_color;

  always #5 clock = ~clock;

  raster_sequencer_if bus();

  raster_sequencer #(.PHASE_CYCLES(1), .TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always @(posedge clock) cyc <= cyc + 1;

  // Downstream sink: record every accepted beat and every done pulse
  always @(negedge clock) begin
    if (!reset && bus.out_pix_valid && bus.in_pix_ready)
      rx_q.push_back(pixel_t'({bus.out_pix_color, bus.out_pix_depth, bus.out_pix_y, bus.out_pix_x}));
    if (!reset && bus.out_tri_done) done_cnt = done_cnt + 1;
  end

  function automatic pixel_t pix_of(input int i);
    pixel_t p;
    p.x     = COORD_W'(256 + 8 * i);
    p.y     = COORD_W'(160 + i);
    p.depth = DEPTH_W'(i);
    p.color = ARGB_W'(32'hF000 + i);
    return p;
  endfunction

  function automatic pixel_t out_pix();
    return pixel_t'({bus.out_pix_color, bus.out_pix_depth, bus.out_pix_y, bus.out_pix_x});
  endfunction

  function automatic logic [4:0] phases();
    return {bus.out_sig_start_new_triangle, bus.out_sig_get_boundary_coords,
            bus.out_sig_form_edges, bus.out_sig_pixel_loop_setup, bus.out_sig_rasterize_pixels};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pixel(input int idx, input bit d);
    pixel_t p;
    p = pix_of(idx);
    bus.in_sig_rasterize_write_pixel = 1'b1;
    bus.in_sig_rasterize_done        = d;
    bus.in_pixel_x     = p.x;
    bus.in_pixel_y     = p.y;
    bus.in_pixel_depth = p.depth;
    bus.in_pixel_color = p.color;
  endtask

  // Model rasterizer: hold a pixel until rasterize_pixels accepts it
  task automatic present_pixel(input int idx, input bit d);
    bit ok;
    ok = 1'b0;
    drive_pixel(idx, d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.out_sig_rasterize_pixels) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
    bus.in_sig_rasterize_write_pixel = 1'b0;
    bus.in_sig_rasterize_done        = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL present_pixel %0d: rasterize_pixels never high within 40 cycles", idx);
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (bus.out_tri_done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    step();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_wait: out_tri_done not seen within 30 cycles", tag);
    end
  endtask

  task automatic send_tri(input string tag);
    bus.in_tri_valid = 1'b1;
    bus.in_tri_xy    = tri_xy;
    bus.in_tri_depth = tri_depth;
    bus.in_tri_color = tri_color;
    @(negedge clock);
    checks++;
    if (bus.out_tri_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: out_tri_ready=%b expected 1", tag, bus.out_tri_ready);
    end
    step();
    bus.in_tri_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.out_tri_ready, bus.out_busy, bus.out_pix_valid, bus.out_tri_done, bus.out_error} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_status: ready/busy/valid/done/err=%b expected 10000",
               {bus.out_tri_ready, bus.out_busy, bus.out_pix_valid, bus.out_tri_done, bus.out_error});
    end
    checks++;
    if (phases() !== 5'b00000) begin
      errors++;
      $display("FAIL reset_phases: got %b expected 00000", phases());
    end
    checks++;
    if (bus.out_tri_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", bus.out_tri_count);
    end
    checks++;
    if ({bus.out_v_xy, bus.out_v_depth, bus.out_v_color} !== '0) begin
      errors++;
      $display("FAIL reset_latched_tri: got %h expected 0", {bus.out_v_xy, bus.out_v_depth, bus.out_v_color});
    end
  endtask

  task automatic test_ignore_idle();
    int d0;
    d0 = done_cnt;
    drive_pixel(99, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clock);
      checks++;
      if ({bus.out_busy, bus.out_pix_valid, bus.out_tri_ready} !== 3'b001) begin
        errors++;
        $display("FAIL idle_ignore_%0d: busy/valid/ready=%b expected 001", k,
                 {bus.out_busy, bus.out_pix_valid, bus.out_tri_ready});
      end
    end
    step();
    bus.in_sig_rasterize_write_pixel = 1'b0;
    bus.in_sig_rasterize_done        = 1'b0;
    checks++;
    if (done_cnt != d0 || bus.out_tri_count !== 16'd0) begin
      errors++;
      $display("FAIL idle_ignore_count: done pulses=%0d count=%0d expected 0 and 0", done_cnt - d0, bus.out_tri_count);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    bus.in_pix_ready = 1'b0;
    send_tri("rstmid");
    present_pixel(30, 1'b0);
    @(negedge clock);
    checks++;
    if (bus.out_pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: out_pix_valid=%b expected 1", bus.out_pix_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.out_pix_valid, bus.out_busy, bus.out_tri_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_state: valid/busy/ready=%b expected 001",
               {bus.out_pix_valid, bus.out_busy, bus.out_tri_ready});
    end
    repeat (3) step();
    checks++;
    if (done_cnt != d0 || bus.out_tri_count !== 16'd0 || bus.out_v_xy !== '0) begin
      errors++;
      $display("FAIL rstmid_no_done: done pulses=%0d count=%0d v_xy=%h expected 0 0 0",
               done_cnt - d0, bus.out_tri_count, bus.out_v_xy);
    end
    bus.in_pix_ready = 1'b1;
  endtask

  task automatic test_basic();
    logic [4:0] exp_ph [5];
    int base, d0;
    exp_ph = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    base = rx_q.size();
    d0   = done_cnt;
    bus.in_pix_ready = 1'b1;
    while (cyc < 10) step();
    send_tri("basic");
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (phases() !== exp_ph[k]) begin
        errors++;
        $display("FAIL basic_phase_N+%0d: got %b expected %b", k + 1, phases(), exp_ph[k]);
      end
      if (k == 0) begin
        checks++;
        if (bus.out_v_xy !== tri_xy || bus.out_v_depth !== tri_depth || bus.out_v_color !== tri_color) begin
          errors++;
          $display("FAIL basic_latch: xy=%h d=%h c=%h expected %h %h %h", bus.out_v_xy,
                   bus.out_v_depth, bus.out_v_color, tri_xy, tri_depth, tri_color);
        end
      end
      step();
    end
    for (int i = 0; i < 5; i++) present_pixel(i, i == 4);
    wait_done("basic");
    step();
    checks++;
    if (rx_q.size() - base != 5) begin
      errors++;
      $display("FAIL basic_beats: got %0d expected 5", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[base + i] !== pix_of(i)) begin
          errors++;
          $display("FAIL basic_pixel_%0d: got %h expected %h", i, rx_q[base + i], pix_of(i));
        end
      end
    end
    checks++;
    if (done_cnt - d0 != 1 || bus.out_tri_count !== 16'd1 || bus.out_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d count=%0d err=%b expected 1 1 0",
               done_cnt - d0, bus.out_tri_count, bus.out_error);
    end
    checks++;
    if ({bus.out_busy, bus.out_tri_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_idle: busy/ready=%b expected 01", {bus.out_busy, bus.out_tri_ready});
    end
  endtask

  task automatic test_backpressure();
    int base;
    base = rx_q.size();
    bus.in_pix_ready = 1'b1;
    send_tri("bp");
    present_pixel(10, 1'b0);
    bus.in_pix_ready = 1'b0;
    drive_pixel(11, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.out_sig_rasterize_pixels, bus.out_pix_valid} !== 2'b01 || out_pix() !== pix_of(10)) begin
        errors++;
        $display("FAIL bp_stall_%0d: rast/valid=%b pix=%h expected 01 %h", k,
                 {bus.out_sig_rasterize_pixels, bus.out_pix_valid}, out_pix(), pix_of(10));
      end
      step();
    end
    bus.in_pix_ready = 1'b1;
    present_pixel(11, 1'b0);
    present_pixel(12, 1'b1);
    wait_done("bp");
    step();
    checks++;
    if (rx_q.size() - base != 3) begin
      errors++;
      $display("FAIL bp_beats: got %0d expected 3", rx_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[base + i] !== pix_of(10 + i)) begin
          errors++;
          $display("FAIL bp_pixel_%0d: got %h expected %h", i, rx_q[base + i], pix_of(10 + i));
        end
      end
    end
    checks++;
    if (bus.out_error !== 1'b0 || bus.out_tri_count !== 16'd2) begin
      errors++;
      $display("FAIL bp_status: err=%b count=%0d expected 0 2", bus.out_error, bus.out_tri_count);
    end
  endtask

  task automatic test_drain();
    int base, d0;
    base = rx_q.size();
    d0   = done_cnt;
    bus.in_pix_ready = 1'b0;
    send_tri("drain");
    present_pixel(20, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.out_busy, bus.out_tri_done, bus.out_pix_valid} !== 3'b101 || out_pix() !== pix_of(20)) begin
        errors++;
        $display("FAIL drain_hold_%0d: busy/done/valid=%b pix=%h expected 101 %h", k,
                 {bus.out_busy, bus.out_tri_done, bus.out_pix_valid}, out_pix(), pix_of(20));
      end
      step();
    end
    bus.in_pix_ready = 1'b1;
    wait_done("drain");
    step();
    checks++;
    if (rx_q.size() - base != 1 || rx_q[rx_q.size() - 1] !== pix_of(20)) begin
      errors++;
      $display("FAIL drain_last_pixel: beats=%0d last=%h expected 1 %h", rx_q.size() - base,
               rx_q[rx_q.size() - 1], pix_of(20));
    end
    checks++;
    if (done_cnt - d0 != 1 || bus.out_tri_count !== 16'd3) begin
      errors++;
      $display("FAIL drain_count: pulses=%0d count=%0d expected 1 3", done_cnt - d0, bus.out_tri_count);
    end
  endtask

  task automatic test_timeout();
    bus.in_pix_ready = 1'b1;
    send_tri("to");
    repeat (4) step();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      checks++;
      if ({bus.out_sig_rasterize_pixels, bus.out_error} !== 2'b10) begin
        errors++;
        $display("FAIL to_raster_%0d: rast/err=%b expected 10", k,
                 {bus.out_sig_rasterize_pixels, bus.out_error});
      end
      step();
    end
    @(negedge clock);
    checks++;
    if ({bus.out_error, bus.out_sig_rasterize_pixels, bus.out_busy} !== 3'b101) begin
      errors++;
      $display("FAIL to_error: err/rast/busy=%b expected 101",
               {bus.out_error, bus.out_sig_rasterize_pixels, bus.out_busy});
    end
    step();
    @(negedge clock);
    checks++;
    if (bus.out_tri_done !== 1'b1 || bus.out_tri_count !== 16'd4) begin
      errors++;
      $display("FAIL to_done: done=%b count=%0d expected 1 4", bus.out_tri_done, bus.out_tri_count);
    end
    step();
    @(negedge clock);
    checks++;
    if ({bus.out_busy, bus.out_tri_ready, bus.out_error} !== 3'b011) begin
      errors++;
      $display("FAIL to_sticky: busy/ready/err=%b expected 011",
               {bus.out_busy, bus.out_tri_ready, bus.out_error});
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_tri_valid = 1'b0;
    bus.in_tri_xy    = '0;
    bus.in_tri_depth = '0;
    bus.in_tri_color = '0;
    bus.in_sig_rasterize_write_pixel = 1'b0;
    bus.in_sig_rasterize_done        = 1'b0;
    bus.in_pixel_x     = '0;
    bus.in_pixel_y     = '0;
    bus.in_pixel_depth = '0;
    bus.in_pixel_color = '0;
    bus.in_pix_ready   = 1'b1;

    tri_xy = '0;
    tri_xy[vx_off(0) +: COORD_W] = 16'd256;
    tri_xy[vy_off(0) +: COORD_W] = 16'd160;
    tri_xy[vx_off(1) +: COORD_W] = 16'd384;
    tri_xy[vy_off(1) +: COORD_W] = 16'd160;
    tri_xy[vx_off(2) +: COORD_W] = 16'd320;
    tri_xy[vy_off(2) +: COORD_W] = 16'd240;
    tri_depth = '0;
    tri_depth[depth_off(0) +: DEPTH_W] = 2'd0;
    tri_depth[depth_off(1) +: DEPTH_W] = 2'd1;
    tri_depth[depth_off(2) +: DEPTH_W] = 2'd2;
    tri_color = '0;
    tri_color[color_off(0) +: ARGB_W] = 16'hF00F;
    tri_color[color_off(1) +: ARGB_W] = 16'hFF00;
    tri_color[color_off(2) +: ARGB_W] = 16'hF0F0;

    test_reset();
    test_ignore_idle();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_drain();
    test_timeout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/raster_sequencer.md
RASTER_SEQUENCER -- requirements
Module: raster_sequencer

Interface
REQ-001 Parameter PHASE_CYCLES, default 1: number of cycles each setup phase signal is held high.
REQ-002 Parameter TIMEOUT, default 4096: maximum RASTER cycles allowed with no write_pixel and no done.
REQ-003 clock  in  1  rising-edge clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_tri_valid  in  1  upstream triangle offered.
REQ-006 out_tri_ready  out  1  sequencer can accept a triangle.
REQ-007 in_tri_xy  in  96  {v2_y,v2_x,v1_y,v1_x,v0_y,v0_x}, 16b screen coordinates each.
REQ-008 in_tri_depth  in  6  {v2,v1,v0} depth, 2b each.
REQ-009 in_tri_color  in  48  {v2,v1,v0} ARGB4444 color.
REQ-010 out_v_xy / out_v_depth / out_v_color  out  96/6/48  latched triangle, held stable to the rasterizer.
REQ-011 out_sig_start_new_triangle, out_sig_get_boundary_coords, out_sig_form_edges, out_sig_pixel_loop_setup, out_sig_rasterize_pixels  out  1 each  rasterizer phase controls.
REQ-012 in_sig_rasterize_write_pixel, in_sig_rasterize_done  in  1 each  rasterizer status.
REQ-013 in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color  in  16/16/2/16  rasterizer pixel outputs.
REQ-014 out_pix_valid  out  1; in_pix_ready  in  1; out_pix_x/y/depth/color  out  16/16/2/16: downstream pixel stream.
REQ-015 out_busy  out  1; out_tri_done  out  1 (pulse); out_tri_count  out  16; out_error  out  1 (sticky).

Function
REQ-016 FSM states: IDLE, START, BOUND, EDGES, SETUP, RASTER, DRAIN, DONE.
REQ-017 out_tri_ready is high only in IDLE; a handshake (in_tri_valid & out_tri_ready) latches all triangle inputs and enters START.
REQ-018 START, BOUND, EDGES and SETUP each last PHASE_CYCLES cycles, in that order; exactly one matching phase control is high, all others low.
REQ-019 Default latency: handshake at cycle N -> start at N+1, boundary N+2, edges N+3, setup N+4, rasterize_pixels first high at N+5.
REQ-020 out_sig_rasterize_pixels = (state==RASTER) & (!out_pix_valid | in_pix_ready), combinational; the rasterizer advances only while it is high.
REQ-021 One-entry pixel buffer: write_pixel sampled while rasterize_pixels is high captures in_pixel_* and sets out_pix_valid.
REQ-022 out_pix_valid clears on in_pix_ready unless a new pixel is captured in the same cycle; buffer contents never change while valid & !ready.
REQ-023 in_sig_rasterize_done in RASTER -> DRAIN; a pixel presented with done in the same cycle is captured first.
REQ-024 DRAIN -> DONE once out_pix_valid is 0 (or is cleared that cycle).
REQ-025 DONE lasts one cycle: out_tri_done = 1, out_tri_count += 1 (wraps at 65535 -> 0), then IDLE.
REQ-026 Timeout counter clears on entry to RASTER and on every write_pixel or done; it counts only while rasterize_pixels is high.
REQ-027 Reaching TIMEOUT sets out_error and forces DRAIN; the triangle is still counted.
REQ-028 Stall cycles (rasterize_pixels low because of backpressure) do not advance the timeout counter.
REQ-029 write_pixel or done outside RASTER is ignored.
REQ-030 out_busy = (state != IDLE).

Reset
REQ-031 Reset forces IDLE and clears out_pix_valid, all phase controls, out_tri_done, out_tri_count, out_error and the timeout counter; latched triangle registers go to 0.
REQ-032 Reset mid-triangle abandons the triangle without a done pulse; out_tri_ready is high the cycle after reset deasserts.

Structure
REQ-033 The shared raster package holds the state encoding, ARGB4444 width, coordinate/depth widths and the vertex-field offsets within in_tri_xy/depth/color.
REQ-034 Sub-module pixel_skid_buf (one-entry valid/ready register) implements REQ-021/022; everything else is flat.

Verification
REQ-035 Triangle (256,160),(384,160),(320,240), colors F00F/FF00/F0F0, handshake at cycle 10 -> phase pulses at cycles 11-14 and rasterize_pixels at 15.
REQ-036 Model rasterizer emits 5 pixels then done, with in_pix_ready=1 -> 5 out_pix_valid beats in order, out_tri_done once, out_tri_count=1.
REQ-037 in_pix_ready held 0 for 20 cycles after the first pixel -> rasterize_pixels low and buffer stable throughout, no pixel lost, out_error=0.
REQ-038 write_pixel and done in the same cycle while ready=0 -> DRAIN holds until ready, then DONE; the last pixel is delivered.
REQ-039 TIMEOUT=16, rasterizer silent -> out_error=1 at the 16th rasterize cycle, DONE follows, count increments.
REQ-040 Reset asserted in RASTER with a pixel pending -> out_pix_valid=0, IDLE, count unchanged, no done pulse.
